// File: rtl/cfs_edge_detect_multi_if.sv
// Bundles the control inputs and status outputs of the multi-channel edge detector.
// Pure wiring, no latency of its own.
// No backpressure; every signal is a level or a single-cycle strobe.
interface cfs_edge_detect_multi_if #(
  parameter int WIDTH  = 8,
  parameter int FILT_W = 4
);
  logic [WIDTH-1:0]   data;
  logic [2*WIDTH-1:0] mode;
  logic [FILT_W-1:0]  filter_len;
  logic [WIDTH-1:0]   irq_en;
  logic [WIDTH-1:0]   clr;
  logic [WIDTH-1:0]   detected;
  logic [WIDTH-1:0]   status;
  logic [WIDTH-1:0]   overflow;
  logic               irq;

  // Register/stimulus side: drives inputs, observes results.
  modport master (
    output data, mode, filter_len, irq_en, clr,
    input  detected, status, overflow, irq
  );

  // Detector side.
  modport slave (
    input  data, mode, filter_len, irq_en, clr,
    output detected, status, overflow, irq
  );
endinterface

// File: rtl/cfs_edge_detect_multi.sv
// Per-channel synchroniser, glitch filter, edge qualifier, sticky status/overflow and irq.
// Latency: SYNC_STAGES + filter_len cycles from first sample of data to detected/status.
// No backpressure; events are never stalled, repeat events while status is set raise overflow.
module cfs_edge_detect_multi #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,   // legal range 1..4
  parameter int               FILT_W      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  cfs_edge_detect_multi_if.slave  ed_if
);

  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be in 1..4");
  end

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  sync_out;
  logic [WIDTH-1:0]  stab_q, stab_d;
  logic [FILT_W-1:0] cnt_q [WIDTH];
  logic [FILT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0]  qual;
  logic [WIDTH-1:0]  detected_q;
  logic [WIDTH-1:0]  status_q, status_d;
  logic [WIDTH-1:0]  overflow_q, overflow_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the raw input, the last stage feeds the filter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VAL;
    end else begin
      sync_q[0] <= ed_if.data;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Glitch filter and edge qualification; >= lets a lowered filter_len release a running count.
  always_comb begin
    stab_d = stab_q;
    qual   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] == stab_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= ed_if.filter_len) begin
        stab_d[i] = sync_out[i];
        cnt_d[i]  = '0;
        // stab keeps tracking even when the channel is disabled, so enabling it later is quiet
        case (ed_if.mode[2*i +: 2])
          2'b01:   qual[i] = sync_out[i];
          2'b10:   qual[i] = ~sync_out[i];
          2'b11:   qual[i] = 1'b1;
          default: qual[i] = 1'b0;
        endcase
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Sticky flags: a new event beats clr for status, clr beats a new event for overflow.
  always_comb begin
    status_d   = qual | (status_q & ~ed_if.clr);
    overflow_d = ~ed_if.clr & (overflow_q | (qual & status_q));
  end

  // Filter state, detected pulse and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      stab_q     <= RESET_VAL;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      detected_q <= '0;
      status_q   <= '0;
      overflow_q <= '0;
    end else begin
      stab_q     <= stab_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      detected_q <= qual;
      status_q   <= status_d;
      overflow_q <= overflow_d;
    end
  end

  assign ed_if.detected = detected_q;
  assign ed_if.status   = status_q;
  assign ed_if.overflow = overflow_q;
  // Gated by reset so the interrupt drops in the same cycle reset is applied.
  assign ed_if.irq      = ~reset & (|(status_q & ed_if.irq_en));

endmodule

// File: tb/tb_cfs_edge_detect_multi.sv
// Directed bench for cfs_edge_detect_multi: expectations are queued with a target cycle
// when stimulus is driven and compared on the falling edge of that cycle.
// WIDTH=8, SYNC_STAGES=2, FILT_W=4, RESET_VAL=0.
module tb_cfs_edge_detect_multi;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;

  cfs_edge_detect_multi_if #(.WIDTH(8), .FILT_W(4)) eif ();

  cfs_edge_detect_multi #(
    .WIDTH(8), .SYNC_STAGES(2), .FILT_W(4), .RESET_VAL(8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ed_if (eif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      tag;
    int         sel;   // 0 detected, 1 status, 2 overflow, 3 irq
    logic [7:0] val;
  } sb_ent_t;

  sb_ent_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic sb_push(input int at, input string tag, input int sel, input logic [7:0] val);
    sb_ent_t e;
    e.at = at; e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare every queued expectation that falls due in this cycle.
  always @(negedge clk) begin
    logic [7:0] obs;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        case (sb[i].sel)
          0:       obs = eif.detected;
          1:       obs = eif.status;
          2:       obs = eif.overflow;
          default: obs = {7'b0, eif.irq};
        endcase
        chk(sb[i].tag, {24'b0, obs}, {24'b0, sb[i].val});
        sb.delete(i);
      end
    end
  end

  initial begin
    int b;
    cyc = 0; n_checks = 0; n_errors = 0;
    reset = 1'b1;
    eif.data = '0; eif.mode = '0; eif.filter_len = '0; eif.irq_en = 8'hFF; eif.clr = '0;
    step(3);
    sb_push(cyc, "rst_det", 0, 8'h00);
    sb_push(cyc, "rst_status", 1, 8'h00);
    sb_push(cyc, "rst_ovf", 2, 8'h00);
    sb_push(cyc, "rst_irq", 3, 8'h00);
    step(1);
    reset = 1'b0;
    step(2);

    // Rising edge on ch0, filter_len=0.
    eif.mode = 16'h0001; eif.filter_len = 4'd0; eif.irq_en = 8'h01;
    b = cyc; eif.data = 8'h01;
    sb_push(b+2, "t1_det_early", 0, 8'h00);
    sb_push(b+2, "t1_irq_early", 3, 8'h00);
    sb_push(b+3, "t1_det", 0, 8'h01);
    sb_push(b+3, "t1_status", 1, 8'h01);
    sb_push(b+3, "t1_irq", 3, 8'h01);
    sb_push(b+4, "t1_det_end", 0, 8'h00);
    step(5);
    eif.clr = 8'h01; step(1); eif.clr = 8'h00;
    sb_push(cyc, "t1_clr_status", 1, 8'h00);
    sb_push(cyc, "t1_clr_irq", 3, 8'h00);

    // ch1 in mode 11 with filter_len=3: a 3-cycle glitch is dropped, a 4-cycle pulse is not.
    eif.mode = 16'h000D; eif.filter_len = 4'd3; step(2);
    b = cyc; eif.data[1] = 1'b1;
    for (int k = 1; k <= 9; k++) sb_push(b+k, "t2_glitch_det", 0, 8'h00);
    sb_push(b+9, "t2_glitch_status", 1, 8'h00);
    step(3); eif.data[1] = 1'b0; step(8);
    b = cyc; eif.data[1] = 1'b1;
    sb_push(b+5,  "t2_rise_early", 0, 8'h00);
    sb_push(b+6,  "t2_rise", 0, 8'h02);
    sb_push(b+6,  "t2_rise_status", 1, 8'h02);
    sb_push(b+7,  "t2_rise_end", 0, 8'h00);
    sb_push(b+9,  "t2_fall_early", 0, 8'h00);
    sb_push(b+10, "t2_fall", 0, 8'h02);
    sb_push(b+10, "t2_fall_ovf", 2, 8'h02);
    sb_push(b+11, "t2_fall_end", 0, 8'h00);
    step(4); eif.data[1] = 1'b0; step(9);
    eif.clr = 8'hFF; step(1); eif.clr = 8'h00;

    // ch2 falling-only, then disabled, then enabled while the line is already high.
    eif.filter_len = 4'd0; eif.mode = 16'h0020; step(2);
    b = cyc; eif.data[2] = 1'b1;
    sb_push(b+3, "t3_rise_masked", 0, 8'h00);
    sb_push(b+6, "t3_fall", 0, 8'h04);
    sb_push(b+6, "t3_fall_status", 1, 8'h04);
    sb_push(b+7, "t3_fall_end", 0, 8'h00);
    step(3); eif.data[2] = 1'b0; step(6);
    eif.mode = 16'h0000;
    b = cyc; eif.data[2] = 1'b1;
    sb_push(b+3, "t3_off_rise", 0, 8'h00);
    sb_push(b+6, "t3_off_fall", 0, 8'h00);
    sb_push(b+8, "t3_off_status", 1, 8'h04);
    step(3); eif.data[2] = 1'b0; step(3); eif.data[2] = 1'b1; step(5);
    eif.mode = 16'h0010;
    b = cyc;
    for (int k = 1; k <= 4; k++) sb_push(b+k, "t3_enable_quiet", 0, 8'h00);
    step(6);
    eif.clr = 8'hFF; step(1); eif.clr = 8'h00;

    // ch3 rising-only: overflow on a repeat, then repeat event together with clr.
    eif.mode = 16'h0040;
    b = cyc; eif.data[3] = 1'b1;
    sb_push(b+3,  "t4_det", 0, 8'h08);
    sb_push(b+3,  "t4_status", 1, 8'h08);
    sb_push(b+3,  "t4_ovf_clear", 2, 8'h00);
    sb_push(b+5,  "t4_fall_quiet", 0, 8'h00);
    sb_push(b+7,  "t4_det2", 0, 8'h08);
    sb_push(b+7,  "t4_ovf", 2, 8'h08);
    sb_push(b+12, "t4_ovf_held", 2, 8'h08);
    sb_push(b+13, "t4_det3", 0, 8'h08);
    sb_push(b+13, "t4_clr_status", 1, 8'h08);
    sb_push(b+13, "t4_clr_ovf", 2, 8'h00);
    step(2); eif.data[3] = 1'b0;
    step(2); eif.data[3] = 1'b1;
    step(4); eif.data[3] = 1'b0;
    step(2); eif.data[3] = 1'b1;
    step(2); eif.clr = 8'h08;
    step(1); eif.clr = 8'h00;
    step(3);

    // ch4 reset while its filter count is at 2 with filter_len=5.
    eif.irq_en = 8'hFF; eif.mode = 16'h0100; eif.filter_len = 4'd5; step(1);
    b = cyc; eif.data[4] = 1'b1;
    sb_push(b+3, "t5_irq_pre", 3, 8'h01);
    step(4);
    reset = 1'b1;
    sb_push(cyc, "t5_irq_in_rst", 3, 8'h00);
    step(1);
    sb_push(cyc, "t5_rst_det", 0, 8'h00);
    sb_push(cyc, "t5_rst_status", 1, 8'h00);
    sb_push(cyc, "t5_rst_ovf", 2, 8'h00);
    reset = 1'b0;
    sb_push(b+8,  "t5_old_count_lost", 0, 8'h00);
    sb_push(b+12, "t5_det_early", 0, 8'h00);
    sb_push(b+13, "t5_det", 0, 8'h10);
    sb_push(b+13, "t5_status", 1, 8'h10);
    sb_push(b+14, "t5_det_end", 0, 8'h00);
    step(12);

    // All channels rise together in mode 11, then clear the odd channels.
    eif.filter_len = 4'd0; eif.mode = 16'h0000; eif.data = 8'h00; step(6);
    eif.clr = 8'hFF; step(1); eif.clr = 8'h00;
    eif.mode = 16'hFFFF; step(1);
    b = cyc; eif.data = 8'hFF;
    sb_push(b+3, "t6_det", 0, 8'hFF);
    sb_push(b+3, "t6_status", 1, 8'hFF);
    sb_push(b+3, "t6_ovf", 2, 8'h00);
    sb_push(b+3, "t6_irq", 3, 8'h01);
    sb_push(b+4, "t6_det_end", 0, 8'h00);
    step(5);
    eif.clr = 8'hAA; step(1); eif.clr = 8'h00;
    sb_push(cyc, "t6_clr_status", 1, 8'h55);
    step(3);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cfs_edge_detect_multi.md
Name: cfs_edge_detect_multi

Overview:
- Multi-channel, parametrised edge detector. Each channel has an input synchroniser, a programmable glitch filter, a per-channel edge-mode select, a sticky status bit, an overflow flag and an interrupt contribution.
- Sits between asynchronous/raw status inputs and the register/interrupt block.
- Replaces per-signal single-edge detector instances with one block per input group.

Parameters:
- WIDTH, 8: number of independent channels.
- SYNC_STAGES, 2: flops in each channel's synchroniser chain; legal range 1..4.
- FILT_W, 4: width of the glitch-filter counter and of the filter_len port.
- RESET_VAL, 0: value loaded into every channel's synchroniser and filtered value at reset.

Ports:
- clk  in  1  block clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data  in  WIDTH  raw channel inputs; may be asynchronous to clk.
- mode  in  2*WIDTH  per-channel edge select; channel i uses bits [2i+1:2i]. 00 = disabled, 01 = rising, 10 = falling, 11 = both.
- filter_len  in  FILT_W  glitch-filter length, shared by all channels.
- irq_en  in  WIDTH  per-channel interrupt enable.
- clr  in  WIDTH  write-1-to-clear strobe for status and overflow.
- detected  out  WIDTH  one-cycle pulse per qualifying edge.
- status  out  WIDTH  sticky edge-seen flag.
- overflow  out  WIDTH  sticky flag: an edge arrived while status was already set.
- irq  out  1  OR over channels of (status & irq_en).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. While reset=1 at a rising edge, the following take effect at that edge:
  - all synchroniser flops and the filtered value stab = RESET_VAL;
  - filter counters = 0;
  - detected, status, overflow = 0;
  - irq = 0 from the same cycle.
- Synchroniser: sync_out[i] is the last flop of a SYNC_STAGES-deep chain sampling data[i].
- Glitch filter, per channel, evaluated every cycle:
  - sync_out == stab: cnt <= 0.
  - sync_out != stab and cnt >= filter_len: stab <= sync_out, cnt <= 0, raise a change event.
  - otherwise: cnt <= cnt + 1.
  - The compare uses >= so that lowering filter_len mid-count cannot wedge the counter.
  - A level must persist filter_len+1 consecutive sync_out cycles to be accepted. Shorter pulses are discarded without any output activity.
- Edge qualification on a change event:
  - rising = new stab is 1; falling = new stab is 0.
  - Qualifies if mode=01 and rising, mode=10 and falling, or mode=11.
  - mode=00 never qualifies, but stab still tracks, so re-enabling a channel produces no spurious edge.
- Latency: if data[i] is first sampled at edge E0, then stab and detected[i] update at edge E0+SYNC_STAGES+filter_len.
- detected[i] is registered and high for exactly one cycle per qualified event. Back-to-back events (filter_len=0, toggling input) give consecutive pulses.
- status[i]:
  - set on a qualified event;
  - cleared when clr[i]=1;
  - a simultaneous event and clr leaves status=1 (set wins).
- overflow[i]:
  - set on a qualified event while status[i]=1 and clr[i]=0;
  - cleared by clr[i];
  - a simultaneous overflow event and clr leaves overflow=0 and status=1.
- irq is combinational from registered status and irq_en. No extra latency.
- First cycle after reset: if data differs from RESET_VAL, the difference is treated as a genuine change and produces an edge after the normal latency. This is intentional, so that a line already active at reset is reported.
- Reset mid-filter: the count is lost. The pending level must re-qualify in full after reset deasserts.
- Changing mode or filter_len takes effect on the next cycle's evaluation. In-flight counts are kept.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.

Test Plan:
- Reset, then data=0x01 with mode ch0=01, SYNC_STAGES=2, filter_len=0 → detected[0] pulses at E0+2 for one cycle; status=0x01; with irq_en=0x01, irq=1.
- filter_len=3: 3-cycle high pulse on ch1 → no detected, status unchanged. 4-cycle high pulse → detected[1] at E0+5; with mode=11, a falling pulse also follows the low transition after the filter delay.
- mode ch2=10: rising then falling edge → only the falling edge pulses. Same with mode=00 → no pulses; then switch to 01 while the line is high → no pulse.
- ch3 rising edge with status[3]=1 → overflow[3]=1. A second event in the same cycle as clr[3]=1 → status[3]=1, overflow[3]=0.
- Assert reset while ch4 is mid-filter (cnt=2, filter_len=5) → all outputs 0 next cycle. A level held after release is reported at E0+SYNC_STAGES+5 measured from release.
- All 8 channels rise in the same cycle with mode=0xFFFF (every channel 11) → detected=0xFF for one cycle and status=0xFF. clr=0xAA → status=0x55.
